// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit counter width: must be able to hold the value WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bi, with borrow-out.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bi_i,
  output logic d_c,
  output logic bo_c
);

  // Difference bit and borrow generate/propagate.
  always_comb begin
    d_c  = a_i ^ b_i ^ bi_i;
    bo_c = (~a_i & b_i) | (~(a_i ^ b_i) & bi_i);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B - BIN, LSB first, behind a
// start/busy/done handshake. One full-subtractor cell, registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fs_d, fs_bo;

  full_subtractor u_fs (
    .a_i  (a_sr_q[0]),
    .b_i  (b_sr_q[0]),
    .bi_i (borrow_q),
    .d_c  (fs_d),
    .bo_c (fs_bo)
  );

  // Next-state, datapath and output-register next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    d_d      = d_q;
    bout_d   = bout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d   = A;
          b_sr_d   = B;
          borrow_d = BIN;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy_d   = 1'b1;
        // New difference bit enters at the MSB so the LSB-first stream lands in place.
        res_d    = (res_q >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        borrow_d = fs_bo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        d_d     = res_q;
        bout_d  = borrow_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign BOUT = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 8, 1 and 16.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_all [3];
  logic [15:0] a_all     [3];
  logic [15:0] b_all     [3];
  logic        bin_all   [3];
  logic        busy_all  [3];
  logic        done_all  [3];
  logic        bout_all  [3];
  logic [15:0] d_all     [3];

  logic        busy8, done8, bout8, busy1, done1, bout1, busy16, done16, bout16;
  logic [7:0]  d8;
  logic [0:0]  d1;
  logic [15:0] d16;

  int unsigned wd [3] = '{8, 1, 16};
  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_all[0]),
    .A(a_all[0][7:0]), .B(b_all[0][7:0]), .BIN(bin_all[0]),
    .busy(busy8), .done(done8), .D(d8), .BOUT(bout8));

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_all[1]),
    .A(a_all[1][0:0]), .B(b_all[1][0:0]), .BIN(bin_all[1]),
    .busy(busy1), .done(done1), .D(d1), .BOUT(bout1));

  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_all[2]),
    .A(a_all[2]), .B(b_all[2]), .BIN(bin_all[2]),
    .busy(busy16), .done(done16), .D(d16), .BOUT(bout16));

  always_comb begin
    busy_all[0] = busy8;  done_all[0] = done8;  bout_all[0] = bout8;  d_all[0] = 16'(d8);
    busy_all[1] = busy1;  done_all[1] = done1;  bout_all[1] = bout1;  d_all[1] = 16'(d1);
    busy_all[2] = busy16; done_all[2] = done16; bout_all[2] = bout16; d_all[2] = d16;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mask_of(input int k);
    return 16'((32'h1 << wd[k]) - 32'h1);
  endfunction

  // Reference: plain integer arithmetic on the operands.
  function automatic longint ref_diff(input int k, input logic [15:0] a,
                                      input logic [15:0] b, input logic bin);
    logic [15:0] m;
    m = mask_of(k);
    return longint'(a & m) - longint'(b & m) - longint'(bin);
  endfunction

  // Issue one operation on DUT k and check latency, busy, D and BOUT.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input string name);
    longint      diff;
    logic [15:0] exp_d;
    logic        exp_b;
    int          lat;
    bit          got;
    diff  = ref_diff(k, a, b, bin);
    exp_d = 16'(diff) & mask_of(k);
    exp_b = (diff < 0);
    start_all[k] = 1'b1; a_all[k] = a; b_all[k] = b; bin_all[k] = bin;
    tick;
    start_all[k] = 1'b0; a_all[k] = 16'($urandom); b_all[k] = 16'($urandom);
    bin_all[k] = 1'($urandom);
    lat = 0; got = 0;
    while (!got && lat < 64) begin
      checks++;
      if (busy_all[k] !== 1'b1) begin
        errors++; $display("FAIL %s busy cycle %0d: got %b want 1", name, lat, busy_all[k]);
      end
      tick;
      lat++;
      if (done_all[k] === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s timeout: no done after %0d cycles", name, lat);
      return;
    end
    checks++;
    if (lat != int'(wd[k]) + 1) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, wd[k] + 1);
    end
    checks++;
    if (d_all[k] !== exp_d || bout_all[k] !== exp_b) begin
      errors++;
      $display("FAIL %s result: got D=%0h BOUT=%b want D=%0h BOUT=%b",
               name, d_all[k], bout_all[k], exp_d, exp_b);
    end
    tick;
    checks++;
    if (done_all[k] !== 1'b0 || busy_all[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got busy=%b done=%b want 0/0", name, busy_all[k], done_all[k]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_all[k] = 1'b0; a_all[k] = '0; b_all[k] = '0; bin_all[k] = 1'b0;
    end
    tick; tick;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy_all[k] !== 1'b0 || done_all[k] !== 1'b0 || d_all[k] !== 16'h0 ||
          bout_all[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: got busy=%b done=%b D=%0h BOUT=%b want all 0",
                 k, busy_all[k], done_all[k], d_all[k], bout_all[k]);
      end
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    run_op(0, 16'd100, 16'd37, 1'b0, "basic");
  endtask

  task automatic test_underflow;
    run_op(0, 16'd0, 16'd1, 1'b0, "underflow_0m1");
    run_op(0, 16'h55, 16'h55, 1'b1, "underflow_bin");
    run_op(0, 16'hFF, 16'h00, 1'b0, "no_borrow_max");
  endtask

  task automatic test_start_while_busy;
    int  lat;
    bit  got;
    bit  extra;
    start_all[0] = 1'b1; a_all[0] = 16'd10; b_all[0] = 16'd3; bin_all[0] = 1'b0;
    tick;
    start_all[0] = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 64) begin
      checks++;
      if (busy_all[0] !== 1'b1) begin
        errors++; $display("FAIL swb busy cycle %0d: got %b want 1", lat, busy_all[0]);
      end
      if (lat == 3) begin
        start_all[0] = 1'b1; a_all[0] = 16'd1; b_all[0] = 16'd2;
      end else begin
        start_all[0] = 1'b0;
      end
      tick;
      lat++;
      if (done_all[0] === 1'b1) got = 1;
    end
    start_all[0] = 1'b0;
    checks++;
    if (!got || lat != 9 || d_all[0] !== 16'd7 || bout_all[0] !== 1'b0) begin
      errors++;
      $display("FAIL swb result: got done=%b lat=%0d D=%0d BOUT=%b want 1/9/7/0",
               got, lat, d_all[0], bout_all[0]);
    end
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (done_all[0] === 1'b1 || busy_all[0] === 1'b1) extra = 1;
    end
    checks++;
    if (extra || d_all[0] !== 16'd7) begin
      errors++;
      $display("FAIL swb queued: got extra_activity=%b D=%0d want 0 and D=7", extra, d_all[0]);
    end
  endtask

  task automatic test_reset_mid;
    bit pulsed;
    start_all[0] = 1'b1; a_all[0] = 16'd200; b_all[0] = 16'd50; bin_all[0] = 1'b0;
    tick;
    start_all[0] = 1'b0;
    for (int c = 1; c < 5; c++) tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_all[0] !== 1'b0 || done_all[0] !== 1'b0 || d_all[0] !== 16'h0 ||
        bout_all[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid outputs: got busy=%b done=%b D=%0h BOUT=%b want all 0",
               busy_all[0], done_all[0], d_all[0], bout_all[0]);
    end
    tick;
    rst_n = 1'b1;
    pulsed = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (done_all[0] !== 1'b0 || busy_all[0] !== 1'b0) pulsed = 1;
    end
    checks++;
    if (pulsed) begin
      errors++; $display("FAIL rst_mid resume: got activity after reset, want none");
    end
    run_op(0, 16'd9, 16'd9, 1'b0, "rst_mid_new");
  endtask

  // start held high: a result every WIDTH+2 cycles, operands taken at acceptance.
  task automatic test_back_to_back;
    logic [15:0] ra [64];
    logic [15:0] rb [64];
    logic        rbin [64];
    logic [15:0] hold_d;
    logic        hold_b;
    longint      diff;
    hold_d = 16'h0; hold_b = 1'b0;
    for (int c = 0; c < 50; c++) begin
      ra[c] = 16'($urandom_range(0, 255)); rb[c] = 16'($urandom_range(0, 255));
      rbin[c] = 1'($urandom);
      start_all[0] = 1'b1; a_all[0] = ra[c]; b_all[0] = rb[c]; bin_all[0] = rbin[c];
      tick;
      checks++;
      if (busy_all[0] !== 1'b1 || done_all[0] !== ((c % 10) == 9)) begin
        errors++;
        $display("FAIL b2b handshake c=%0d: got busy=%b done=%b want 1/%b",
                 c, busy_all[0], done_all[0], ((c % 10) == 9));
      end
      if ((c % 10) == 9) begin
        diff   = ref_diff(0, ra[c - 9], rb[c - 9], rbin[c - 9]);
        hold_d = 16'(diff) & 16'h00FF;
        hold_b = (diff < 0);
      end
      checks++;
      if (d_all[0] !== hold_d || bout_all[0] !== hold_b) begin
        errors++;
        $display("FAIL b2b data c=%0d: got D=%0h BOUT=%b want D=%0h BOUT=%b",
                 c, d_all[0], bout_all[0], hold_d, hold_b);
      end
    end
    start_all[0] = 1'b0;
    tick;
  endtask

  task automatic test_sweep;
    run_op(1, 16'd0, 16'd1, 1'b0, "w1_under");
    run_op(1, 16'd1, 16'd0, 1'b1, "w1_bin");
    run_op(2, 16'h0000, 16'hFFFF, 1'b1, "w16_min");
    run_op(2, 16'hFFFF, 16'h0000, 1'b1, "w16_max");
    for (int i = 0; i < 10; i++) begin
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), "w1_rand");
      run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), "w16_rand");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_underflow;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
